// File: rtl/core_pkg.sv
// Shared core definitions: RV32 major opcodes, issue FSM state encoding,
// and small opcode classification helpers used by the issue logic.
package core_pkg;

   localparam logic [6:0] OP_R       = 7'b0110011;
   localparam logic [6:0] OP_I_ALU   = 7'b0010011;
   localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_I_JALR  = 7'b1100111;
   localparam logic [6:0] OP_S       = 7'b0100011;
   localparam logic [6:0] OP_B       = 7'b1100011;
   localparam logic [6:0] OP_U_LUI   = 7'b0110111;
   localparam logic [6:0] OP_U_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_J       = 7'b1101111;

   localparam int unsigned INFLIGHT_W   = 3;
   localparam logic [2:0]  INFLIGHT_MAX = 3'd7;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } issue_state_t;

   // Instruction reads rs1
   function automatic logic uses_rs1(input logic [6:0] op);
      case (op)
         OP_R, OP_I_ALU, OP_I_LOAD, OP_I_JALR, OP_S, OP_B: uses_rs1 = 1'b1;
         OP_U_LUI, OP_U_AUIPC, OP_J:                       uses_rs1 = 1'b0;
         default:                                          uses_rs1 = 1'b0;
      endcase
   endfunction

   // Instruction reads rs2
   function automatic logic uses_rs2(input logic [6:0] op);
      uses_rs2 = (op == OP_R) || (op == OP_S) || (op == OP_B);
   endfunction

   // Instruction writes rd (stores and branches do not)
   function automatic logic writes_rd(input logic [6:0] op);
      writes_rd = (op != OP_S) && (op != OP_B);
   endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register scoreboard for the issue stage: busy bit per x1..x31 and a
// count of issued, not yet written-back register writers.
// Build option: ISSUE_CTRL_SCOREBOARD_EN enables tracking; without it the
// hazard output is 0 and inflight is tied to 0.
// Ports: CLK/RST (async active-low), held instruction opcode/rd/rs1/rs2,
// issue strobe, write-back WB_VALID/WB_RD, hazard_c (comb), inflight.
module issue_scoreboard
   import core_pkg::*;
#(
   parameter int unsigned OPCODE_W = 7
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [OPCODE_W-1:0]   hold_opcode,
   input  logic [4:0]            hold_rd,
   input  logic [4:0]            hold_rs1,
   input  logic [4:0]            hold_rs2,
   input  logic                  issue,
   input  logic                  WB_VALID,
   input  logic [4:0]            WB_RD,
   output logic                  hazard_c,
   output logic [INFLIGHT_W-1:0] inflight
);

`ifdef ISSUE_CTRL_SCOREBOARD_EN
   logic [31:1] busy_q;
   logic [31:0] busy_eff;
   logic [31:0] busy_n;
   logic [6:0]  op7;
   logic        set_c;
   logic        clr_c;
   logic        sb_unused;

   assign op7   = 7'(hold_opcode);
   assign set_c = issue & (hold_rd != 5'd0) & writes_rd(op7);
   assign clr_c = WB_VALID & (WB_RD != 5'd0);

   // Busy view with this cycle's write-back already applied (bypass); bit 0 is x0
   always_comb begin
      busy_eff = {busy_q, 1'b0};
      if (clr_c) busy_eff[WB_RD] = 1'b0;
   end

   // Set after clear so a same-cycle set/clear of one register stays busy
   always_comb begin
      busy_n = busy_eff;
      if (set_c) busy_n[hold_rd] = 1'b1;
   end

   assign sb_unused = busy_n[0];

   assign hazard_c = (uses_rs1(op7) & busy_eff[hold_rs1]) |
                     (uses_rs2(op7) & busy_eff[hold_rs2]);

   // Busy vector and saturating in-flight count
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         busy_q   <= '0;
         inflight <= '0;
      end else begin
         busy_q <= busy_n[31:1];
         if (set_c && !clr_c && (inflight != INFLIGHT_MAX))
            inflight <= inflight + INFLIGHT_W'(1);
         else if (clr_c && !set_c && (inflight != '0))
            inflight <= inflight - INFLIGHT_W'(1);
      end
   end
`else
   logic sb_unused;

   assign sb_unused = ^{CLK, RST, hold_opcode, hold_rd, hold_rs1, hold_rs2,
                        issue, WB_VALID, WB_RD};
   assign hazard_c  = 1'b0;
   assign inflight  = '0;
`endif

endmodule

// File: rtl/issue_ctrl.sv
// Issue stage: one-entry holding register between decode and execute with
// register hazard checking through issue_scoreboard.
// Build option: ISSUE_CTRL_SCOREBOARD_EN (hazard/in-flight tracking).
// Ports: CLK, RST (async active-low), FLUSH; DEC_* decoded instruction in,
// DEC_STALL back-pressure; EXEC_* instruction offered to execute with
// EXEC_READY handshake; WB_VALID/WB_RD write-back; INFLIGHT count.
module issue_ctrl
   import core_pkg::*;
#(
   parameter int unsigned OPCODE_W = 7
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                FLUSH,
   input  logic                DEC_VALID,
   input  logic [31:0]         DEC_PC,
   input  logic [OPCODE_W-1:0] DEC_OPCODE,
   input  logic [4:0]          DEC_RD,
   input  logic [4:0]          DEC_RS1,
   input  logic [4:0]          DEC_RS2,
   input  logic [31:0]         DEC_IMM,
   output logic                DEC_STALL,
   output logic                EXEC_VALID,
   output logic [31:0]         EXEC_PC,
   output logic [OPCODE_W-1:0] EXEC_OPCODE,
   output logic [4:0]          EXEC_RD,
   output logic [31:0]         EXEC_IMM,
   input  logic                EXEC_READY,
   input  logic                WB_VALID,
   input  logic [4:0]          WB_RD,
   output logic [2:0]          INFLIGHT
);

   issue_state_t state_q;
   issue_state_t state_n;
   logic [4:0]   rs1_q;
   logic [4:0]   rs2_q;
   logic         hold_c;
   logic         hazard_c;
   logic         issue_c;
   logic         accept_c;

   assign hold_c     = (state_q == ST_HOLD);
   assign EXEC_VALID = hold_c & ~hazard_c & ~FLUSH & (INFLIGHT != INFLIGHT_MAX);
   assign issue_c    = EXEC_VALID & EXEC_READY;
   assign DEC_STALL  = hold_c & ~issue_c;
   assign accept_c   = DEC_VALID & ~DEC_STALL & ~FLUSH;

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= ST_EMPTY;
      else      state_q <= state_n;
   end

   // Next state; FLUSH empties the slot regardless of handshakes
   always_comb begin
      state_n = state_q;
      if (FLUSH) begin
         state_n = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (accept_c) state_n = ST_HOLD;
            ST_HOLD:  if (issue_c && !accept_c) state_n = ST_EMPTY;
            default:  state_n = ST_EMPTY;
         endcase
      end
   end

   // Holding register, loaded on accept and driven straight to execute
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         EXEC_PC     <= '0;
         EXEC_OPCODE <= '0;
         EXEC_RD     <= '0;
         EXEC_IMM    <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
      end else if (accept_c) begin
         EXEC_PC     <= DEC_PC;
         EXEC_OPCODE <= DEC_OPCODE;
         EXEC_RD     <= DEC_RD;
         EXEC_IMM    <= DEC_IMM;
         rs1_q       <= DEC_RS1;
         rs2_q       <= DEC_RS2;
      end
   end

   issue_scoreboard #(
      .OPCODE_W (OPCODE_W)
   ) u_scoreboard (
      .CLK         (CLK),
      .RST         (RST),
      .hold_opcode (EXEC_OPCODE),
      .hold_rd     (EXEC_RD),
      .hold_rs1    (rs1_q),
      .hold_rs2    (rs2_q),
      .issue       (issue_c),
      .WB_VALID    (WB_VALID),
      .WB_RD       (WB_RD),
      .hazard_c    (hazard_c),
      .inflight    (INFLIGHT)
   );

endmodule
